// File: rtl/mem_arb_if.sv
// Requester-side and memory-side signals of the four-port memory arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the memory model.
interface mem_arb_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  logic [3:0]          req;
  logic [3:0]          write;
  logic [4*MEM_AW-1:0] addr;
  logic [4*MEM_DW-1:0] wdata;
  logic [3:0]          gnt;
  logic [3:0]          rvld;
  logic [3:0]          err;
  logic [MEM_DW-1:0]   rdata;
  logic                busy;
  logic                mem_req;
  logic                mem_write;
  logic [MEM_AW-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_wdata;
  logic                mem_rdata_vld;
  logic [MEM_DW-1:0]   mem_rdata;

  modport slave (
    input  req, write, addr, wdata, mem_rdata_vld, mem_rdata,
    output gnt, rvld, err, rdata, busy, mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req, write, addr, wdata, mem_rdata_vld, mem_rdata,
    input  gnt, rvld, err, rdata, busy, mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter that gives four requesters access to a single memory port.
// Reads wait for returned data, and a read that waits too long ends with an err pulse.
module mem_arb #(
  parameter int MEM_AW  = 16,
  parameter int MEM_DW  = 32,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        rvld_q, rvld_d;
  logic [3:0]        err_q, err_d;
  logic [MEM_DW-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_write_q, mem_write_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]        pick;
  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              timed_out;

  // Returns {found, index}: the first set request at or above p, searching upward mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign pick       = rr_pick(bus.req, ptr_q);
  assign pick_found = pick[2];
  assign pick_idx   = pick[1:0];
  assign timed_out  = (cnt_q == 8'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      cnt_q       <= 8'd0;
      gnt_q       <= 4'd0;
      rvld_q      <= 4'd0;
      err_q       <= 4'd0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvld_q      <= rvld_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // mem_write_q holds the direction latched for the command now being issued.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          owner_d = pick_idx;
          ptr_d   = pick_idx + 2'd1;
        end
      end
      ISSUE: begin
        if (mem_write_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = 8'd0;
        end
      end
      WAIT_RD: begin
        if (bus.mem_rdata_vld || timed_out) state_d = IDLE;
        else                                cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle early, so every registered output lines up with state_q.
  always_comb begin
    gnt_d       = 4'd0;
    rvld_d      = 4'd0;
    err_d       = 4'd0;
    rdata_d     = rdata_q;
    mem_req_d   = 1'b0;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          mem_req_d   = 1'b1;
          gnt_d       = 4'b0001 << pick_idx;
          mem_write_d = bus.write[pick_idx];
          mem_addr_d  = bus.addr[32'(pick_idx) * MEM_AW +: MEM_AW];
          mem_wdata_d = bus.write[pick_idx] ? bus.wdata[32'(pick_idx) * MEM_DW +: MEM_DW] : '0;
        end
      end
      WAIT_RD: begin
        if (bus.mem_rdata_vld) begin
          rvld_d  = 4'b0001 << owner_q;
          rdata_d = bus.mem_rdata;
        end else if (timed_out) begin
          err_d   = 4'b0001 << owner_q;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvld      = rvld_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios followed by random transactions.
// Each transaction is checked against a round-robin reference model.
module tb_mem_arb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if #(.MEM_AW(AW), .MEM_DW(DW)) bus();

  mem_arb #(.MEM_AW(AW), .MEM_DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] addr_a [4];
  logic [DW-1:0] wdata_a[4];
  logic [1:0]    ptr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] r, input logic [3:0] w);
    bus.req   = r;
    bus.write = w;
    bus.addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
    bus.wdata = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};
  endtask

  // Reference arbitration: the first requester at or after ptr, searching upward mod 4.
  function automatic int rr_winner(input logic [3:0] r, input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (int'(p) + i) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"},       bus.gnt,       0);
    check({tag, ".rvld"},      bus.rvld,      0);
    check({tag, ".err"},       bus.err,       0);
    check({tag, ".rdata"},     bus.rdata,     0);
    check({tag, ".busy"},      bus.busy,      0);
    check({tag, ".mem_req"},   bus.mem_req,   0);
    check({tag, ".mem_write"}, bus.mem_write, 0);
    check({tag, ".mem_addr"},  bus.mem_addr,  0);
    check({tag, ".mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // One full transaction, started while the arbiter is idle. A dly above TO means no data comes back.
  task automatic do_txn(input logic [3:0] r, input logic [3:0] w, input int dly,
                        input logic [DW-1:0] rd, input string tag, output int win);
    logic [3:0] oh;
    win = rr_winner(r, ptr_m);
    oh  = 4'b0001 << win;
    drive_cmd(r, w);
    bus.mem_rdata_vld = 1'($urandom);
    bus.mem_rdata     = $urandom;
    tick();
    check({tag, ".gnt"},       bus.gnt,       oh);
    check({tag, ".mem_req"},   bus.mem_req,   1);
    check({tag, ".mem_write"}, bus.mem_write, w[win]);
    check({tag, ".mem_addr"},  bus.mem_addr,  addr_a[win]);
    check({tag, ".mem_wdata"}, bus.mem_wdata, w[win] ? wdata_a[win] : 0);
    check({tag, ".rv_err"},    {bus.rvld, bus.err}, 0);
    check({tag, ".busy"},      bus.busy,      1);
    ptr_m = 2'(win + 1);
    bus.req           = 4'($urandom);
    bus.mem_rdata_vld = 1'($urandom);
    if (w[win]) begin
      tick();
      check({tag, ".gnt_off"},  bus.gnt,      0);
      check({tag, ".req_off"},  bus.mem_req,  0);
      check({tag, ".idle"},     bus.busy,     0);
      check({tag, ".addr_hold"}, bus.mem_addr, addr_a[win]);
    end else begin
      tick();
      for (int i = 0; i <= TO; i++) begin
        bus.req = 4'($urandom);
        if (i == dly) begin
          bus.mem_rdata_vld = 1'b1;
          bus.mem_rdata     = rd;
          tick();
          check({tag, ".rvld"},  bus.rvld,  oh);
          check({tag, ".err"},   bus.err,   0);
          check({tag, ".rdata"}, bus.rdata, rd);
          check({tag, ".idle"},  bus.busy,  0);
          break;
        end
        bus.mem_rdata_vld = 1'b0;
        tick();
        if (i == TO) begin
          check({tag, ".err"},   bus.err,   oh);
          check({tag, ".rvld"},  bus.rvld,  0);
          check({tag, ".rdata"}, bus.rdata, 0);
          check({tag, ".idle"},  bus.busy,  0);
        end else begin
          check({tag, ".wait_busy"}, bus.busy, 1);
          check({tag, ".wait_out"},  {bus.rvld, bus.err, bus.gnt, 3'(bus.mem_req)}, 0);
        end
      end
    end
    bus.req           = 4'd0;
    bus.mem_rdata_vld = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int win;
    int exp_order[5];
    logic [3:0] r, w;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    bus.req = 4'd0; bus.write = 4'd0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata_vld = 1'b0; bus.mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin addr_a[k] = '0; wdata_a[k] = '0; end
    ptr_m = 2'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_noreq.busy", bus.busy, 0);
    check("idle_noreq.gnt",  bus.gnt,  0);

    // All four requesters writing: rotation starts at requester 0.
    for (int k = 0; k < 4; k++) begin addr_a[k] = AW'($urandom); wdata_a[k] = $urandom; end
    for (int n = 0; n < 5; n++) begin
      do_txn(4'b1111, 4'b1111, 0, '0, "rr4", win);
      check("rr4.order", win, exp_order[n]);
    end

    addr_a[0]  = 16'h0010;
    wdata_a[0] = 32'hDEADBEEF;
    do_txn(4'b0001, 4'b0001, 0, '0, "wr1", win);
    check("wr1.addr",  bus.mem_addr,  16'h0010);
    check("wr1.wdata", bus.mem_wdata, 32'hDEADBEEF);

    addr_a[2] = 16'h0042;
    do_txn(4'b0100, 4'b0000, 2, 32'h12345678, "rd2", win);
    check("rd2.rdata_const", bus.rdata, 32'h12345678);
    tick();
    check("rd2.after_busy", bus.busy, 0);
    check("rd2.rvld_once",  bus.rvld, 0);

    // Requester 1 read that times out, then pending requester 3 is served.
    do_txn(4'b0010, 4'b0000, TO + 5, '0, "to1", win);
    check("to1.win", win, 1);
    do_txn(4'b1000, 4'b1000, 0, '0, "wr3", win);
    check("wr3.win", win, 3);

    do_txn(4'b0001, 4'b0000, TO, 32'hA5A5_0F0F, "edge_vld", win);

    // Reset during WAIT_RD abandons the read.
    drive_cmd(4'b0001, 4'b0000);
    tick();
    bus.req = 4'b1111;
    tick();
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    bus.req = 4'd0;
    tick();
    rst = 1'b0;
    ptr_m = 2'd0;
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata     = 32'hFFFF_FFFF;
    tick();
    check("rst_mid.no_rvld", bus.rvld, 0);
    check("rst_mid.no_busy", bus.busy, 0);
    bus.mem_rdata_vld = 1'b0;
    do_txn(4'b1100, 4'b0100, 1, 32'h0BAD_CAFE, "post_rst", win);
    check("post_rst.win", win, 2);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin addr_a[k] = AW'($urandom); wdata_a[k] = $urandom; end
      r = 4'($urandom_range(1, 15));
      w = 4'($urandom);
      do_txn(r, w, $urandom_range(0, TO + 2), $urandom, "rand", win);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_AW, default 16, memory address width.
REQ-002 Parameter MEM_DW, default 32, memory data width.
REQ-003 Parameter TIMEOUT, default 255, max wait cycles for read data (1..255, 8-bit counter).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  one clock; reset is asynchronous and active-high.
REQ-006 req  in  4  per-requester transaction request, bit k = requester k.
REQ-007 write  in  4  per-requester direction, 1=write, 0=read; valid while req[k]=1.
REQ-008 addr  in  4*MEM_AW  per-requester address, requester k at bits [k*MEM_AW +: MEM_AW].
REQ-009 wdata  in  4*MEM_DW  per-requester write data, same slicing with MEM_DW.
REQ-010 gnt  out  4  one-cycle pulse, command of requester k is on memory port this cycle.
REQ-011 rvld  out  4  one-cycle pulse, read data for requester k on rdata.
REQ-012 err  out  4  one-cycle pulse, read for requester k timed out.
REQ-013 rdata  out  MEM_DW  shared read return data.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 mem_req, mem_write  out  1 each  memory command strobe and direction.
REQ-016 mem_addr  out  MEM_AW; mem_wdata  out  MEM_DW  memory command fields.
REQ-017 mem_rdata_vld  in  1; mem_rdata  in  MEM_DW  memory read return.

Function
REQ-018 States IDLE, ISSUE, WAIT_RD; all memory-side and requester-side outputs registered.
REQ-019 IDLE: if any req bit set, select winner round-robin starting at pointer ptr, upward mod 4; latch write/addr/wdata of winner; go ISSUE; else stay IDLE.
REQ-020 ISSUE: mem_req=1, gnt[owner]=1, mem_write/mem_addr/mem_wdata = latched command, exactly one cycle.
REQ-021 ISSUE -> IDLE if latched write=1; ISSUE -> WAIT_RD if write=0, wait counter cleared to 0.
REQ-022 Latency: req sampled high in IDLE at edge t -> mem_req and gnt high in cycle t+1; throughput one transaction per 2 cycles for writes.
REQ-023 ptr SHALL update to (owner+1) mod 4 on entering ISSUE; ptr reset value 0.
REQ-024 Requester SHALL drop req[k] in the cycle after gnt[k]; req[k] still high in the next IDLE is a new request.
REQ-025 Requests arriving or changing outside IDLE are ignored until next IDLE; latched command is not affected.
REQ-026 WAIT_RD: on mem_rdata_vld=1, register mem_rdata to rdata and pulse rvld[owner] next cycle; go IDLE.
REQ-027 WAIT_RD: counter increments each cycle without vld; at counter == TIMEOUT with no vld, pulse err[owner], rdata=0, go IDLE.
REQ-028 vld in same cycle counter reaches TIMEOUT: treated as data (rvld, no err).
REQ-029 mem_rdata_vld in IDLE or ISSUE: ignored, no rvld pulse.
REQ-030 mem_wdata driven from latched value for writes; held at 0 for reads.
REQ-031 mem_addr, mem_write, mem_wdata hold last values outside ISSUE; only mem_req qualifies them.
REQ-032 At most one bit of gnt, rvld, err is high in any cycle; rvld and err never both high.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, ptr=0, counter=0, and all outputs (gnt, rvld, err, rdata, busy, mem_req, mem_write, mem_addr, mem_wdata) to 0.
REQ-034 Reset mid-transaction abandons it: no rvld/err for the owner, later mem_rdata_vld ignored per REQ-029.
REQ-035 First grant after reset release starts search at requester 0.

Verification
REQ-036 Single write: req=0001, write=0001, addr0=0x0010, wdata0=0xDEADBEEF -> next cycle mem_req=1, mem_write=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF, gnt=0001.
REQ-037 All four req held high with writes -> gnt order 0001,0010,0100,1000,0001 on ISSUE cycles every 2 cycles.
REQ-038 Read req2 addr=0x0042, mem_rdata_vld with mem_rdata=0x12345678 three cycles after ISSUE -> rvld=0100, rdata=0x12345678 next cycle, busy low after.
REQ-039 Read req1 with TIMEOUT=4 and no vld -> err=0010 once, rdata=0, no rvld, arbiter returns to IDLE and serves pending req3.
REQ-040 Assert rst during WAIT_RD, then vld -> all outputs 0, no rvld; next grant after release goes to lowest set req from 0.
